// File: rtl/collision_sweep_if.sv
// collision_sweep_if: groups the sweep sequencer's control, BRAM and collision-stage signals.
// Latency: none (wires only).
// Backpressure: none; all transfers are single-cycle strobes with fixed latencies.
// master = the sequencer (collision_sweep), slave = the BRAM/collision side.
interface collision_sweep_if #(
  parameter int ADDR_W = 12
);
  logic                   start_in;        // one-cycle sweep request
  logic                   busy_out;        // sweep in progress
  logic                   done_out;        // one-cycle pulse after final write-back
  logic [ADDR_W-1:0]      bram_raddr_out;  // BRAM read address
  logic                   bram_ren_out;    // BRAM read enable
  logic [8:0][7:0]        bram_rdata_in;   // BRAM read data, 9 direction densities
  logic [8:0][7:0]        coll_data_out;   // densities to collision stage
  logic                   coll_valid_out;  // coll_data_out valid
  logic [8:0][7:0]        coll_result_in;  // collided densities
  logic                   coll_done_in;    // coll_result_in valid
  logic [ADDR_W-1:0]      bram_waddr_out;  // BRAM write address
  logic                   bram_we_out;     // BRAM write enable
  logic [8:0][7:0]        bram_wdata_out;  // BRAM write data
  logic                   error_out;       // sticky protocol error

  modport master (
    input  start_in, bram_rdata_in, coll_result_in, coll_done_in,
    output busy_out, done_out, bram_raddr_out, bram_ren_out, coll_data_out,
           coll_valid_out, bram_waddr_out, bram_we_out, bram_wdata_out, error_out
  );

  modport slave (
    output start_in, bram_rdata_in, coll_result_in, coll_done_in,
    input  busy_out, done_out, bram_raddr_out, bram_ren_out, coll_data_out,
           coll_valid_out, bram_waddr_out, bram_we_out, bram_wdata_out, error_out
  );
endinterface

// File: rtl/collision_sweep.sv
// collision_sweep: walks every lattice cell once, feeds densities to collision, writes results back.
// Latency: cell k read at 1+k after start, written at 2+k+BRAM_LATENCY+COLLIDE_LATENCY, done at N+L_B+L_C+2.
// Backpressure: none; one read per cycle, the collision stage is a fixed-latency pipeline.
//
// Ports: clk_in, rst_in (synchronous, active-high) plus bus (collision_sweep_if.master):
//   start_in/busy_out/done_out control, bram_raddr/ren/rdata read port, coll_data/valid
//   to collision, coll_result/done from collision, bram_waddr/we/wdata write port, error_out.
// Optional: define COLLISION_SWEEP_CHECK_EN to build the sticky protocol checker driving
//   error_out; otherwise error_out is tied low.
module collision_sweep #(
  parameter int GRID_W          = 64,
  parameter int GRID_H          = 48,
  parameter int ADDR_W          = 12,
  parameter int BRAM_LATENCY    = 2,
  parameter int COLLIDE_LATENCY = 20
) (
  input  logic                clk_in,
  input  logic                rst_in,
  collision_sweep_if.master   bus
);

  localparam int N     = GRID_W * GRID_H;
  localparam int TAG_D = BRAM_LATENCY + COLLIDE_LATENCY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t              state;
  logic                ren_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic                busy_q;
  logic                done_q;
  logic                tail_vld_d;   // tail of the tag line was valid last cycle

  // Address tag line: each issued address travels with its valid bit for the full
  // read + collision latency, so the tail lines up with coll_done_in.
  logic [ADDR_W-1:0]   tag_sr [TAG_D];
  logic [TAG_D-1:0]    tag_vld;

  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [8:0][7:0]     wdata_q;

  // Sequencer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      ren_q      <= 1'b0;
      raddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tail_vld_d <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      tail_vld_d <= tag_vld[TAG_D-1];
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            state   <= ISSUE;
            ren_q   <= 1'b1;
            raddr_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (raddr_q == LAST_ADDR) begin
            state <= DRAIN;
            ren_q <= 1'b0;
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        DRAIN: begin
          // Line empty now, and its last entry reached the tail last cycle: that
          // entry's write-back is being driven this cycle, so the sweep is complete.
          if (tag_vld == '0 && tail_vld_d) begin
            state  <= FINISH;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag / valid delay line
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tag_vld <= '0;
      for (int i = 0; i < TAG_D; i++) tag_sr[i] <= '0;
    end else begin
      tag_vld   <= {tag_vld[TAG_D-2:0], ren_q};
      tag_sr[0] <= raddr_q;
      for (int i = 1; i < TAG_D; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  // Write-back. Gating on the tail valid bit drops results that belong to reads
  // issued before a reset, since the reset emptied the tag line.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (bus.coll_done_in && tag_vld[TAG_D-1]) begin
      we_q    <= 1'b1;
      waddr_q <= tag_sr[TAG_D-1];
      wdata_q <= bus.coll_result_in;
    end else begin
      we_q    <= 1'b0;
    end
  end

`ifdef COLLISION_SWEEP_CHECK_EN
  logic err_q;
  // Any disagreement between the collision done strobe and the expected tail is sticky.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_q <= 1'b0;
    end else if (bus.coll_done_in != tag_vld[TAG_D-1]) begin
      err_q <= 1'b1;
    end
  end
  assign bus.error_out = err_q;
`else
  assign bus.error_out = 1'b0;
`endif

  assign bus.busy_out       = busy_q;
  assign bus.done_out       = done_q;
  assign bus.bram_ren_out   = ren_q;
  assign bus.bram_raddr_out = raddr_q;
  assign bus.coll_data_out  = bus.bram_rdata_in;
  // The tag valid bits already form ren delayed per cycle; tap after BRAM latency.
  assign bus.coll_valid_out = tag_vld[BRAM_LATENCY-1];
  assign bus.bram_we_out    = we_q;
  assign bus.bram_waddr_out = waddr_q;
  assign bus.bram_wdata_out = wdata_q;

endmodule

// File: tb/tb_collision_sweep.sv
// tb_collision_sweep: scoreboard bench for collision_sweep, 2x2 and 1x1 grids side by side.
// Latency: models a 2-cycle BRAM and a 20-cycle collision stage returning each byte +1.
// Backpressure: none; expectations are pushed at stimulus time and popped by a monitor.
module tb_collision_sweep;

  localparam int LB = 2;
  localparam int LC = 20;
  localparam int INF = 32'h7fffffff;
`ifdef COLLISION_SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    int          cyc;
    logic [11:0] addr;
    logic [71:0] dat;
    logic [71:0] old;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic start_v;
  logic inj;
  logic seed_en;
  logic mon_en = 1'b0;
  logic zchk = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  collision_sweep_if #(.ADDR_W(12)) b4 ();
  collision_sweep_if #(.ADDR_W(12)) b1 ();

  collision_sweep #(.GRID_W(2), .GRID_H(2), .ADDR_W(12), .BRAM_LATENCY(LB), .COLLIDE_LATENCY(LC))
    dut4 (.clk_in(clk), .rst_in(rst), .bus(b4));
  collision_sweep #(.GRID_W(1), .GRID_H(1), .ADDR_W(12), .BRAM_LATENCY(LB), .COLLIDE_LATENCY(LC))
    dut1 (.clk_in(clk), .rst_in(rst), .bus(b1));

  function automatic logic [71:0] add1(input logic [71:0] x);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = x[i*8 +: 8] + 8'd1;
    return r;
  endfunction

  // DUT outputs gathered per instance (0 = 2x2, 1 = 1x1)
  logic [1:0]  m_ren, m_we, m_vld, m_done, m_busy, m_err;
  logic [11:0] m_raddr [2];
  logic [11:0] m_waddr [2];
  logic [71:0] m_wdata [2];
  logic [71:0] m_cdata [2];
  assign m_ren  = {b1.bram_ren_out,   b4.bram_ren_out};
  assign m_we   = {b1.bram_we_out,    b4.bram_we_out};
  assign m_vld  = {b1.coll_valid_out, b4.coll_valid_out};
  assign m_done = {b1.done_out,       b4.done_out};
  assign m_busy = {b1.busy_out,       b4.busy_out};
  assign m_err  = {b1.error_out,      b4.error_out};
  assign m_raddr[0] = b4.bram_raddr_out;  assign m_raddr[1] = b1.bram_raddr_out;
  assign m_waddr[0] = b4.bram_waddr_out;  assign m_waddr[1] = b1.bram_waddr_out;
  assign m_wdata[0] = b4.bram_wdata_out;  assign m_wdata[1] = b1.bram_wdata_out;
  assign m_cdata[0] = b4.coll_data_out;   assign m_cdata[1] = b1.coll_data_out;

  // Environment: BRAM (2-cycle read) and collision pipeline (20 cycles, +1 per byte)
  logic [71:0] seedv [2][4];
  logic [71:0] mem   [2][4];
  logic [71:0] p1    [2];
  logic [71:0] rdq   [2];
  logic [19:0] cv    [2];
  logic [71:0] cd    [2][20];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (seed_en) begin
        for (int i = 0; i < 4; i++) mem[d][i] <= seedv[d][i];
        cv[d] <= '0;
      end else begin
        if (m_we[d]) mem[d][m_waddr[d][1:0]] <= m_wdata[d];
        cv[d] <= {cv[d][18:0], m_vld[d]};
        for (int j = 19; j > 0; j--) cd[d][j] <= cd[d][j-1];
        cd[d][0] <= m_cdata[d];
      end
      p1[d]  <= mem[d][m_raddr[d][1:0]];
      rdq[d] <= p1[d];
    end
  end

  assign b4.start_in       = start_v;
  assign b1.start_in       = start_v;
  assign b4.bram_rdata_in  = rdq[0];
  assign b1.bram_rdata_in  = rdq[1];
  assign b4.coll_done_in   = cv[0][19] | inj;
  assign b1.coll_done_in   = cv[1][19] | inj;
  assign b4.coll_result_in = add1(cd[0][19]);
  assign b1.coll_result_in = add1(cd[1][19]);

  // Reference model state
  int          nc [2];
  logic [71:0] refm [2][4];
  ev_t         rq [2][$];
  ev_t         vq [2][$];
  ev_t         wq [2][$];
  int          dq [2][$];
  int          bs [2];
  int          be [2];
  int          ef [2];
  int          idle_from [2];

  task automatic chk(input int d, input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle each stream must match the head of its queue or be idle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        ev_t e;
        if (rq[d].size() > 0 && rq[d][0].cyc == cyc) begin
          e = rq[d].pop_front();
          chk(d, "ren", m_ren[d], 1);
          chk(d, "raddr", m_raddr[d], e.addr);
        end else chk(d, "ren", m_ren[d], 0);
        if (vq[d].size() > 0 && vq[d][0].cyc == cyc) begin
          e = vq[d].pop_front();
          chk(d, "coll_valid", m_vld[d], 1);
          chk(d, "coll_data", m_cdata[d], e.dat);
        end else chk(d, "coll_valid", m_vld[d], 0);
        if (wq[d].size() > 0 && wq[d][0].cyc == cyc) begin
          e = wq[d].pop_front();
          chk(d, "we", m_we[d], 1);
          chk(d, "waddr", m_waddr[d], e.addr);
          chk(d, "wdata", m_wdata[d], e.dat);
        end else chk(d, "we", m_we[d], 0);
        if (dq[d].size() > 0 && dq[d][0] == cyc) begin
          void'(dq[d].pop_front());
          chk(d, "done", m_done[d], 1);
        end else chk(d, "done", m_done[d], 0);
        chk(d, "busy", m_busy[d], (cyc >= bs[d] && cyc <= be[d]) ? 72'd1 : 72'd0);
        chk(d, "error", m_err[d], (cyc >= ef[d]) ? 72'd1 : 72'd0);
        if (zchk) begin
          chk(d, "idle_raddr", m_raddr[d], 0);
          chk(d, "idle_waddr", m_waddr[d], 0);
          chk(d, "idle_wdata", m_wdata[d], 0);
        end
      end
    end
  end

  // One stimulus cycle; expectations are derived from the sweep timing rules.
  task automatic step(input bit st, input bit rs, input bit ij);
    int c;
    c = cyc;
    start_v = st;
    rst     = rs;
    inj     = ij;
    if (st && !rs) begin
      for (int d = 0; d < 2; d++) begin
        if (c >= idle_from[d]) begin
          for (int k = 0; k < nc[d]; k++) begin
            rq[d].push_back('{cyc: c + 1 + k, addr: 12'(k), dat: '0, old: '0});
            vq[d].push_back('{cyc: c + 1 + k + LB, addr: 12'(k), dat: refm[d][k], old: '0});
            wq[d].push_back('{cyc: c + 2 + k + LB + LC, addr: 12'(k), dat: add1(refm[d][k]), old: refm[d][k]});
            refm[d][k] = add1(refm[d][k]);
          end
          dq[d].push_back(c + nc[d] + LB + LC + 2);
          bs[d]        = c + 1;
          be[d]        = c + nc[d] + LB + LC + 1;
          idle_from[d] = c + nc[d] + LB + LC + 3;
        end
      end
    end
    if (ij && CHK) begin
      for (int d = 0; d < 2; d++) if (c + 1 < ef[d]) ef[d] = c + 1;
    end
    @(posedge clk);
    #1;
    start_v = 1'b0;
    rst     = 1'b0;
    inj     = 1'b0;
    if (rs) begin
      for (int d = 0; d < 2; d++) begin
        int nef;
        nef = INF;
        // Results still in the collision stage arrive with no tag behind them.
        foreach (wq[d][i]) begin
          refm[d][wq[d][i].addr[1:0]] = wq[d][i].old;
          if (wq[d][i].cyc >= c + 2 && wq[d][i].cyc < nef) nef = wq[d][i].cyc;
        end
        rq[d].delete();
        vq[d].delete();
        wq[d].delete();
        dq[d].delete();
        if (be[d] > c) be[d] = c;
        idle_from[d] = c + 1;
        ef[d] = CHK ? nef : INF;
      end
    end
  endtask

  initial begin
    int g;
    nc[0] = 4;
    nc[1] = 1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        seedv[d][i] = {$urandom, $urandom, $urandom};
        refm[d][i]  = seedv[d][i];
      end
      bs[d] = INF;
      be[d] = -1;
      ef[d] = INF;
      idle_from[d] = 0;
    end
    rst     = 1'b1;
    start_v = 1'b0;
    inj     = 1'b0;
    seed_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    seed_en = 1'b0;
    mon_en  = 1'b1;
    zchk    = 1'b1;
    step(0, 1, 0);

    // Reset then idle: all outputs low
    repeat (10) step(0, 0, 0);
    zchk = 1'b0;

    // Full sweep
    step(1, 0, 0);
    repeat (35) step(0, 0, 0);

    // Restart requests at cycle 10 and on the done cycle of the 2x2 sweep
    step(1, 0, 0);
    repeat (9) step(0, 0, 0);
    step(1, 0, 0);
    repeat (17) step(0, 0, 0);
    step(1, 0, 0);
    repeat (40) step(0, 0, 0);

    // Reset at cycle 15 of a sweep, then a clean sweep
    step(1, 0, 0);
    repeat (14) step(0, 0, 0);
    step(0, 1, 0);
    repeat (40) step(0, 0, 0);
    step(1, 0, 0);
    repeat (40) step(0, 0, 0);

    // Spurious coll_done_in with an empty pipeline, 5 cycles after reset
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);
    step(0, 0, 1);
    repeat (8) step(0, 0, 0);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // Randomized sweeps with stray start pulses
    for (int it = 0; it < 8; it++) begin
      step(1, 0, 0);
      g = $urandom_range(0, 40);
      repeat (g) step($urandom_range(0, 5) == 0, 0, 0);
    end
    repeat (40) step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
